// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and the MEM stage.
// Data accesses win; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              d_stall,
  output logic [15:0]       conflict_cnt
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef struct packed {
    logic              en;
    logic [3:0]        we;
    logic [ADDR_W-3:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  logic [1:0]  rd_owner;
  logic [3:0]  starve_cnt;
  logic [15:0] conflict_q;
  logic        gnt_d, gnt_if;
  mem_cmd_t    cmd;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

  // Grants are forced low while reset is held so every output reads 0.
  always_comb begin
    gnt_d  = 1'b0;
    gnt_if = 1'b0;
    if (!rst) begin
      if (d_req && !(if_req && starve_cnt == STARVE_LIM)) gnt_d  = 1'b1;
      else if (if_req)                                    gnt_if = 1'b1;
    end
  end

  always_comb begin
    cmd = '0;
    if (gnt_d) begin
      cmd.en    = 1'b1;
      cmd.we    = d_we ? d_be : 4'b0000;
      cmd.addr  = d_addr[ADDR_W-1:2];
      cmd.wdata = d_wdata;
    end else if (gnt_if) begin
      cmd.en   = 1'b1;
      cmd.addr = if_addr[ADDR_W-1:2];
    end
  end

  assign mem_en    = cmd.en;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  assign d_gnt    = gnt_d;
  assign if_gnt   = gnt_if;
  assign if_stall = if_req & ~gnt_if & ~rst;
  assign d_stall  = d_req & ~gnt_d & ~rst;

  assign if_rvalid = (rd_owner == OWN_IF);
  assign d_rvalid  = (rd_owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign conflict_cnt = conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner   <= OWN_NONE;
      starve_cnt <= 4'd0;
      conflict_q <= 16'd0;
    end else begin
      if (gnt_if)             rd_owner <= OWN_IF;
      else if (gnt_d && !d_we) rd_owner <= OWN_D;
      else                    rd_owner <= OWN_NONE;

      // Only a data grant that leaves fetch waiting counts toward starvation.
      if (gnt_if || !if_req)                   starve_cnt <= 4'd0;
      else if (gnt_d && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;

      if (if_req && d_req && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch stage and the load/store (MEM) stage of the 5-stage pipeline. Grants at most one access per cycle, returns read data one cycle after the grant, and produces the stall signals the hazard logic folds into the PC / IF_ID stall and MEM-stage freeze. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, byte address width from both requesters
- DATA_W, 32, data width (fixed to 32; byte enables are 4 bits)
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
- if_rdata  out  32  instruction word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  d_rdata valid (cycle after a load grant only)
- d_rdata  out  32  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  4  byte write enables (0 for reads)
- mem_addr  out  ADDR_W-2  word address (byte address [ADDR_W-1:2])
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we=0
- if_stall  out  1  if_req & ~if_gnt
- d_stall  out  1  d_req & ~d_gnt
- conflict_cnt  out  16  saturating count of cycles with both requests asserted

## Operation
- Grant logic combinational from requests and starve_cnt: only d_req -> data; only if_req -> fetch; both -> data unless starve_cnt == STARVE_MAX, then fetch; neither -> no grant.
- Memory command driven combinationally from granted requester in grant cycle: mem_en=1, mem_addr=addr[ADDR_W-1:2], mem_we = d_we ? d_be : 0, mem_wdata=d_wdata. No grant -> mem_en=0, mem_we=0, addr/wdata don't-care (drive 0).
- Low address bits [1:0] ignored; no alignment fault.
- Registered owner state: rd_owner in {NONE, IF, D} set at each edge from the current read grant (store grant -> NONE). Next cycle: owner IF -> if_rvalid=1, if_rdata=mem_rdata; owner D -> d_rvalid=1, d_rdata=mem_rdata. rdata outputs are 0 when corresponding rvalid=0.
- starve_cnt (4 bits): +1 (saturate at STARVE_MAX) on a data grant while if_req=1; cleared on a fetch grant or when if_req=0.
- conflict_cnt: +1 each cycle with if_req & d_req, saturates at 16'hFFFF.
- Store with d_be=0: granted, mem_en=1, mem_we=0, no rvalid.

## Timing
- Grant/stall: zero-latency (same cycle as request). Read data: exactly 1 cycle after grant. Store: completes in grant cycle.
- Back-to-back grants every cycle permitted; rvalid of grant N and grant N+1 coincide with no bubble.
- Rvalid for a fetch and a data read never in the same cycle.
- Reset (async, any time): rd_owner=NONE, starve_cnt=0, conflict_cnt=0; all outputs 0 immediately; a read in flight is dropped (no rvalid after reset release). Outputs purely combinational from requests resume first cycle rst=0.
- Request dropped before grant: no access, no state change besides starve_cnt clear rule.

## Test plan
- Fetch alone: if_req=1, if_addr=0x0000_0010, mem holds 0x2008_0005 at word 4 -> same cycle if_gnt=1, mem_addr=4, mem_we=0; next cycle if_rvalid=1, if_rdata=0x2008_0005; if_stall never 1.
- Load vs fetch collision: both requesting, d_addr=0x40 -> d_gnt=1, if_stall=1, mem_addr=0x10; next cycle d_rvalid=1 with word 0x10, if_gnt=1; conflict_cnt=1.
- Starvation: if_req and d_req held high, STARVE_MAX=4 -> data granted cycles 0-3, fetch granted cycle 4, data again cycle 5; if_stall high exactly 4 cycles.
- Store then load same address: d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0xAABB_CCDD over 0x1111_1111 -> mem_we=4'b0011, no d_rvalid; following load returns 0x1111_CCDD.
- Reset mid-read: fetch granted, rst pulsed before next edge -> if_rvalid stays 0, all outputs 0 during reset, conflict_cnt=0 after.
- Counter saturation: force 65540 conflict cycles -> conflict_cnt holds 0xFFFF.
